// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_txn_sequencer: frames one command byte plus 0..3 read bytes over
// spi_master, owns chip select and assembles the read bytes MSB-first.
// Revision 1.0
// ----------------------------------------------------------------------------
module spi_txn_sequencer #(
  parameter int CS_SETUP_CYC = 4,
  parameter int CS_HOLD_CYC  = 4,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [7:0]  i_req_cmd,
  input  logic [1:0]  i_req_nrd,
  output logic        o_rsp_valid,
  output logic [23:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic        o_cs_n,
  output logic        o_spi_start,
  output logic [7:0]  o_spi_data_in,
  input  logic        i_spi_busy,
  input  logic        i_spi_new_data,
  input  logic [7:0]  i_spi_data_out
);

  localparam int c_MAX_SH  = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int c_MAX_CYC = (TIMEOUT_CYC > c_MAX_SH) ? TIMEOUT_CYC : c_MAX_SH;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX    = {c_CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [7:0]          r_cmd;
  logic [1:0]          r_nrd;
  logic [1:0]          r_byte_idx;
  logic [23:0]         r_rsp_data;
  logic                r_rsp_err;
  logic                r_cs_n;
  logic                r_req_ready;
  logic [7:0]          r_spi_data_in;

  logic w_accept;
  logic w_setup_done;
  logic w_rx;
  logic w_last;
  logic w_timeout;
  logic w_hold_done;

  // r_req_ready is only ever set while IDLE, so it also qualifies the state
  assign w_accept     = r_req_ready & i_req_valid;
  assign w_setup_done = (r_state == S_SETUP) && (r_cnt == c_SETUP_LAST);
  assign w_rx         = (r_state == S_WAIT) && i_spi_new_data;
  assign w_last       = (r_byte_idx == r_nrd);
  assign w_timeout    = (r_state == S_WAIT) && !i_spi_new_data && (r_cnt == c_TO_LAST);
  assign w_hold_done  = (r_state == S_HOLD) && (r_cnt == c_HOLD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // spi_start is decoded from state so a new byte can launch one clock after new_data
  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b1;
    o_spi_start = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_accept) begin
          w_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_setup_done) begin
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        if (!i_spi_busy) begin
          o_spi_start = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_spi_new_data) begin
          w_next = w_last ? S_HOLD : S_SEND;
        end else if (w_timeout) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_hold_done) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_cmd         <= 8'h00;
      r_nrd         <= 2'd0;
      r_byte_idx    <= 2'd0;
      r_rsp_data    <= 24'h000000;
      r_rsp_err     <= 1'b0;
      r_cs_n        <= 1'b1;
      r_req_ready   <= 1'b0;
      r_spi_data_in <= 8'h00;
    end else begin
      r_req_ready <= (w_next == S_IDLE);

      // One counter serves setup, timeout and hold; it restarts on every state change
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_accept) begin
        r_cmd      <= i_req_cmd;
        r_nrd      <= i_req_nrd;
        r_rsp_data <= 24'h000000;
        r_rsp_err  <= 1'b0;
        r_byte_idx <= 2'd0;
        r_cs_n     <= 1'b0;
      end

      if (w_setup_done) begin
        r_spi_data_in <= r_cmd;
      end

      if (w_rx) begin
        if (r_byte_idx != 2'd0) begin
          r_rsp_data <= {r_rsp_data[15:0], i_spi_data_out};
        end
        if (!w_last) begin
          r_byte_idx    <= r_byte_idx + 2'd1;
          r_spi_data_in <= 8'h00;
        end
      end

      if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end

      if (w_hold_done) begin
        r_cs_n <= 1'b1;
      end
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_err     = r_rsp_err;
  assign o_cs_n        = r_cs_n;
  assign o_spi_data_in = r_spi_data_in;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
`default_nettype none
// Bench for spi_txn_sequencer: behavioural spi_master model, bus monitor and
// a transaction-level expectation for each request.
module tb_spi_txn_sequencer;

  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int TMO   = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [1:0]  req_nrd;
  logic        rsp_valid;
  logic [23:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        cs_n;
  logic        spi_start;
  logic [7:0]  spi_data_in;
  logic        spi_busy;
  logic        spi_new_data;
  logic [7:0]  spi_data_out;

  always #5 clk = ~clk;

  spi_txn_sequencer #(
    .CS_SETUP_CYC (SETUP),
    .CS_HOLD_CYC  (HOLD),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_cmd      (req_cmd),
    .i_req_nrd      (req_nrd),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_rsp_err      (rsp_err),
    .o_busy         (busy),
    .o_cs_n         (cs_n),
    .o_spi_start    (spi_start),
    .o_spi_data_in  (spi_data_in),
    .i_spi_busy     (spi_busy),
    .i_spi_new_data (spi_new_data),
    .i_spi_data_out (spi_data_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // spi_master model state and monitor records
  logic [7:0] q_rx[$];
  logic [7:0] q_din[$];
  int   m_left = 0;
  int   m_lat  = 0;
  int   m_cnt  = 0;
  bit   m_pend = 1'b0;
  bit   force_busy = 1'b0;
  int   cyc = 0;
  int   n_start, n_fall, n_rise, n_rsp;
  int   fall_cyc, rise_cyc, first_start_cyc, last_start_cyc, last_nd_cyc, rsp_cyc;
  bit   nd_seen, gap_bad;
  logic prev_cs_n = 1'b1;
  logic [23:0] got_data;
  logic        got_err;

  // Inputs change 2 time units after posedge; outputs are sampled on negedge
  initial begin
    logic s_start, s_cs, s_rv;
    logic [7:0] s_din;
    spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = 8'h00;
    forever begin
      @(posedge clk); #2;
      spi_new_data = 1'b0;
      if (m_pend) begin
        if (m_cnt == 0) begin
          spi_new_data = 1'b1;
          spi_data_out = (q_rx.size() > 0) ? q_rx.pop_front() : 8'h00;
          m_pend = 1'b0;
        end else begin
          m_cnt--;
        end
      end
      spi_busy = m_pend | force_busy;
      @(negedge clk);
      cyc++;
      s_start = spi_start; s_din = spi_data_in; s_cs = cs_n; s_rv = rsp_valid;
      if (spi_new_data) begin
        nd_seen = 1'b1; last_nd_cyc = cyc;
      end
      if (s_start) begin
        n_start++;
        q_din.push_back(s_din);
        if (n_start == 1) first_start_cyc = cyc;
        if (nd_seen && (cyc - last_nd_cyc != 1) && !force_busy) gap_bad = 1'b1;
        last_start_cyc = cyc;
        if (m_left > 0) begin
          m_left--; m_pend = 1'b1; m_cnt = m_lat;
        end
      end
      if (prev_cs_n && !s_cs) begin n_fall++; fall_cyc = cyc; end
      if (!prev_cs_n && s_cs) begin n_rise++; rise_cyc = cyc; end
      prev_cs_n = s_cs;
      if (s_rv) begin
        n_rsp++; rsp_cyc = cyc; got_data = rsp_data; got_err = rsp_err;
      end
    end
  end

  task automatic clear_mon();
    n_start = 0; n_fall = 0; n_rise = 0; n_rsp = 0;
    nd_seen = 1'b0; gap_bad = 1'b0;
    q_din.delete();
  endtask

  // bytes[31:24] answers the command byte, then one byte per read
  task automatic issue(input logic [7:0] cmd, input logic [1:0] nrd, input logic [31:0] bytes,
                       input int nresp, input int lat, input bit hold_valid);
    bit ok;
    @(posedge clk); #1;
    clear_mon();
    q_rx.delete();
    for (int i = 0; i < 4; i++) q_rx.push_back(bytes[31-8*i -: 8]);
    m_left = nresp; m_lat = lat;
    req_cmd = cmd; req_nrd = nrd; req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    check("accept_wait", 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (!hold_valid) begin
      req_valid = 1'b0;
      req_cmd   = 8'($urandom);
      req_nrd   = 2'($urandom);
    end
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    req_valid = 1'b0;
    check("rsp_wait", 32'(ok), 32'd1);
  endtask

  task automatic verify(input string nm, input logic [7:0] cmd, input logic [1:0] nrd,
                        input logic [31:0] bytes, input int nresp, input bit setup_chk);
    int          total, recv;
    bit          err_e;
    logic [23:0] exp_d;
    repeat (3) @(negedge clk);
    total = int'(nrd) + 1;
    err_e = (nresp < total);
    recv  = err_e ? nresp : total;
    exp_d = 24'h0;
    for (int i = 1; i < recv; i++) exp_d = {exp_d[15:0], bytes[31-8*i -: 8]};
    check({nm, "_rsp_data"}, 32'(rsp_data), 32'(exp_d));
    check({nm, "_rsp_err"}, 32'(rsp_err), 32'(err_e));
    check({nm, "_pulse_data"}, 32'(got_data), 32'(exp_d));
    check({nm, "_pulse_err"}, 32'(got_err), 32'(err_e));
    check({nm, "_rsp_pulses"}, n_rsp, 1);
    check({nm, "_starts"}, n_start, err_e ? nresp + 1 : total);
    for (int i = 0; i < q_din.size(); i++)
      check({nm, "_data_in"}, 32'(q_din[i]), (i == 0) ? 32'(cmd) : 32'h0);
    check({nm, "_cs_falls"}, n_fall, 1);
    check({nm, "_cs_rises"}, n_rise, 1);
    check({nm, "_end_state"}, {29'd0, cs_n, req_ready, busy}, {29'd0, 1'b1, 1'b1, 1'b0});
    if (setup_chk) check({nm, "_setup_cyc"}, first_start_cyc - fall_cyc, SETUP);
    // negedge sampling puts new_data half a clock before the edge that uses it
    if (!err_e) begin
      check({nm, "_hold_cyc"}, rise_cyc - last_nd_cyc, HOLD + 1);
      check({nm, "_gap"}, 32'(gap_bad), 32'd0);
    end else begin
      check({nm, "_timeout_cyc"}, rise_cyc - last_start_cyc, TMO + HOLD + 1);
    end
    check({nm, "_rsp_vs_cs"}, rsp_cyc, rise_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  c;
    logic [1:0]  n;
    logic [31:0] b;
    int          r;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 8'h00; req_nrd = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp", {7'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
    check("rst_data_in", 32'(spi_data_in), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);

    issue(8'h48, 2'd0, 32'h5A000000, 1, 20, 1'b0);
    wait_rsp(); verify("t1", 8'h48, 2'd0, 32'h5A000000, 1, 1'b1);

    issue(8'h00, 2'd3, 32'hAA123456, 4, 2, 1'b0);
    wait_rsp(); verify("t2", 8'h00, 2'd3, 32'hAA123456, 4, 1'b1);

    issue(8'h3C, 2'd2, 32'h00BEEF00, 3, 0, 1'b0);
    wait_rsp(); verify("t3", 8'h3C, 2'd2, 32'h00BEEF00, 3, 1'b1);

    issue(8'h91, 2'd1, 32'h11223344, 0, 0, 1'b0);
    wait_rsp(); verify("t4", 8'h91, 2'd1, 32'h11223344, 0, 1'b1);

    issue(8'hC3, 2'd2, 32'h01A5C3E7, 3, 3, 1'b1);
    wait_rsp(); verify("t5_hold", 8'hC3, 2'd2, 32'h01A5C3E7, 3, 1'b1);

    force_busy = 1'b1;
    issue(8'h7E, 2'd1, 32'h00CAFE00, 2, 1, 1'b0);
    repeat (12) @(negedge clk);
    check("t5_busy_no_start", n_start, 0);
    @(posedge clk); #1 force_busy = 1'b0;
    wait_rsp(); verify("t5_busy", 8'h7E, 2'd1, 32'h00CAFE00, 2, 1'b0);
    check("t5_busy_delay", 32'((first_start_cyc - fall_cyc) > SETUP), 32'd1);

    for (int t = 0; t < 6; t++) begin
      c = 8'($urandom); n = 2'($urandom_range(0, 3)); b = $urandom;
      issue(c, n, b, int'(n) + 1, int'($urandom_range(0, 5)), 1'b0);
      wait_rsp(); verify("rnd", c, n, b, int'(n) + 1, 1'b1);
    end

    c = 8'($urandom); n = 2'($urandom_range(1, 3)); b = $urandom;
    r = int'($urandom_range(1, int'(n)));
    issue(c, n, b, r, int'($urandom_range(0, 4)), 1'b0);
    wait_rsp(); verify("rnd_to", c, n, b, r, 1'b1);

    issue(8'h21, 2'd1, 32'h0, 0, 0, 1'b0);
    for (int k = 0; k < 100 && n_start == 0; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async", {29'd0, cs_n, spi_start, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_no_rsp", n_rsp, 0);
    check("t6_idle", {30'd0, cs_n, req_ready}, {30'd0, 1'b1, 1'b1});
    check("t6_rsp_clear", 32'(rsp_data), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
